// File: rtl/tone_pkg.sv
// tone_pkg: note classes, FSM states, window bounds and nominal periods for the tone detector.
package tone_pkg;
  typedef enum logic [2:0] {N_C, N_D, N_E, N_F, N_G, N_A, N_B} note_e;
  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_e;
  localparam int PW = 19;
  // contiguous half-open windows: each class spans [its LO, next-lower class LO)
  localparam logic [PW-1:0] C_HI = 19'd400000;
  localparam logic [PW-1:0] C_LO = 19'd361374;
  localparam logic [PW-1:0] D_LO = 19'd321950;
  localparam logic [PW-1:0] E_LO = 19'd294857;
  localparam logic [PW-1:0] F_LO = 19'd270723;
  localparam logic [PW-1:0] G_LO = 19'd241187;
  localparam logic [PW-1:0] A_LO = 19'd214875;
  localparam logic [PW-1:0] B_LO = 19'd190000;
  localparam int P_C = 382219;
  localparam int P_D = 340530;
  localparam int P_E = 303370;
  localparam int P_F = 286344;
  localparam int P_G = 255102;
  localparam int P_A = 227273;
  localparam int P_B = 202478;
  function automatic logic [6:0] onehot(input note_e n);
    return 7'b1 << n;
  endfunction
endpackage

// File: rtl/period_classifier.sv
// period_classifier: maps a measured period onto a note class plus a matched flag.
module period_classifier
  import tone_pkg::*;
(
  input  logic [PW-1:0] i_p,
  output note_e         o_cls,
  output logic          o_matched
);
  always_comb begin
    o_matched = i_p >= B_LO && i_p < C_HI;
    o_cls = i_p >= C_LO ? N_C :
            i_p >= D_LO ? N_D :
            i_p >= E_LO ? N_E :
            i_p >= F_LO ? N_F :
            i_p >= G_LO ? N_G :
            i_p >= A_LO ? N_A : N_B;
  end
endmodule

// File: rtl/tone_detector.sv
// tone_detector: measures the period of a square wave and locks a one-hot note
// after LOCK_CNT consecutive periods of the same class.
module tone_detector
  import tone_pkg::*;
#(
  parameter int TIMEOUT  = 400000,
  parameter int LOCK_CNT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          tone_in,
  output logic [6:0]    note,
  output logic          valid,
  output logic [PW-1:0] period
);
  localparam logic [PW-1:0] TMO = PW'(TIMEOUT);
  logic [2:0] r_sync;
  logic [PW-1:0] r_cnt, r_period, w_period_nx, w_p;
  logic [6:0] r_note, w_note_nx;
  logic [7:0] r_cand_cnt, w_cand_cnt_nx, w_run;
  logic r_valid, w_edge, w_timeout, w_matched, w_same, w_lock, w_kill, w_upd;
  state_e r_state, w_state_nx;
  note_e r_cand, w_cand_nx, w_cls;

  period_classifier u_cls (.i_p(w_p), .o_cls(w_cls), .o_matched(w_matched));

  assign w_edge    = r_sync[1] & ~r_sync[2];
  // an edge landing on the timeout cycle wins and is measured as p = TIMEOUT
  assign w_timeout = !w_edge && r_cnt == TMO - 1'b1;
  assign w_p       = r_cnt == TMO ? TMO : r_cnt + 1'b1;
  assign w_same    = r_note == onehot(w_cls);
  assign w_run     = (r_cand_cnt != 8'd0 && r_cand == w_cls) ? r_cand_cnt + 8'd1 : 8'd1;
  assign w_lock    = w_run >= 8'(LOCK_CNT);
  assign w_kill    = !enable || (w_timeout && r_state != IDLE);
  assign w_upd     = w_edge && r_state != IDLE && w_matched && (w_same || w_lock);
  assign note      = r_note;
  assign valid     = r_valid;
  assign period    = r_period;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= '0;
      r_cnt      <= '0;
      r_state    <= IDLE;
      r_cand     <= N_C;
      r_cand_cnt <= '0;
      r_note     <= '0;
      r_valid    <= 1'b0;
      r_period   <= '0;
    end else begin
      r_sync     <= {r_sync[1:0], tone_in};
      r_cnt      <= (!enable || w_edge) ? '0 : r_cnt == TMO ? r_cnt : r_cnt + 1'b1;
      r_state    <= w_state_nx;
      r_cand     <= w_cand_nx;
      r_cand_cnt <= w_cand_cnt_nx;
      r_note     <= w_note_nx;
      r_valid    <= |w_note_nx;
      r_period   <= w_period_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_cand_nx     = r_cand;
    w_cand_cnt_nx = r_cand_cnt;
    if (w_kill) begin
      w_state_nx    = IDLE;
      w_cand_cnt_nx = '0;
    end else if (w_edge) begin
      if (r_state == IDLE) w_state_nx = MEASURE;
      else if (!w_matched) begin
        w_state_nx    = MEASURE;
        w_cand_cnt_nx = '0;
      end else if (w_same) w_cand_cnt_nx = '0;
      else if (w_lock) begin
        w_state_nx    = LOCKED;
        w_cand_cnt_nx = '0;
      end else begin
        w_cand_nx     = w_cls;
        w_cand_cnt_nx = w_run;
      end
    end
  end

  always_comb begin
    w_note_nx   = r_note;
    w_period_nx = r_period;
    if (w_kill) begin
      w_note_nx   = '0;
      w_period_nx = '0;
    end else if (w_edge && r_state != IDLE && !w_matched) w_note_nx = '0;
    else if (w_upd) begin
      w_note_nx   = onehot(w_cls);
      w_period_nx = w_p;
    end
  end
endmodule

// File: tb/tb_tone_detector.sv
// tb_tone_detector: directed checks of locking, note changes, windows, timeout, enable and reset.
module tb_tone_detector;
  import tone_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, tone_in = 1'b0;
  logic [6:0] note;
  logic valid;
  logic [18:0] period;
  int total = 0, bad = 0, since = 0;

  tone_detector dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .tone_in(tone_in),
    .note(note), .valid(valid), .period(period)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      since++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [6:0] n, input logic [18:0] p);
    chk({tag, ".note"}, 32'(note), 32'(n));
    chk({tag, ".valid"}, 32'(valid), 32'(|n));
    chk({tag, ".period"}, 32'(period), 32'(p));
  endtask

  task automatic rise(input int p);
    cyc(p / 2 - since);
    tone_in = 1'b0;
    cyc(p - since);
    tone_in = 1'b1;
    since = 0;
  endtask

  // next rise after p cycles; note just before and just after the decision cycle
  task automatic edge_chk(input string tag, input int p, input logic [6:0] pre, input logic [6:0] n, input logic [18:0] per);
    rise(p);
    cyc(2);
    chk({tag, ".pre"}, 32'(note), 32'(pre));
    cyc(1);
    outs(tag, n, per);
  endtask

  task automatic go_low_then_first_rise(input int p);
    cyc(p - since);
    tone_in = 1'b1;
    since = 0;
  endtask

  initial begin
    cyc(2);
    outs("reset", 7'h00, 19'd0);
    chk("reset.state", 32'(dut.r_state), 32'(IDLE));
    rst_n = 1'b1;
    cyc(5);
    tone_in = 1'b1;
    since = 0;
    cyc(3);
    chk("first_edge.state", 32'(dut.r_state), 32'(MEASURE));
    chk("first_edge.note", 32'(note), 32'(0));
    edge_chk("c2", P_C, 7'h00, 7'h00, 19'd0);
    edge_chk("c3", P_C, 7'h00, 7'h00, 19'd0);
    edge_chk("c4", P_C, 7'h00, 7'h01, 19'd382219);
    chk("c4.state", 32'(dut.r_state), 32'(LOCKED));
    edge_chk("a1", P_A, 7'h01, 7'h01, 19'd382219);
    edge_chk("a2", P_A, 7'h01, 7'h01, 19'd382219);
    edge_chk("a3", P_A, 7'h01, 7'h20, 19'd227273);
    edge_chk("b1", P_B, 7'h20, 7'h20, 19'd227273);
    edge_chk("b2", P_B, 7'h20, 7'h20, 19'd227273);
    edge_chk("b3", P_B, 7'h20, 7'h40, 19'd202478);
    edge_chk("b_top", 214874, 7'h40, 7'h40, 19'd214874);
    edge_chk("a_bot1", 214875, 7'h40, 7'h40, 19'd214874);
    edge_chk("a_bot2", 214875, 7'h40, 7'h40, 19'd214874);
    edge_chk("a_bot3", 214875, 7'h40, 7'h20, 19'd214875);
    edge_chk("short", 150000, 7'h20, 7'h00, 19'd214875);
    chk("short.state", 32'(dut.r_state), 32'(MEASURE));
    edge_chk("rb1", P_B, 7'h00, 7'h00, 19'd214875);
    edge_chk("rb2", P_B, 7'h00, 7'h00, 19'd214875);
    edge_chk("rb3", P_B, 7'h00, 7'h40, 19'd202478);
    cyc(P_B / 2 - since);
    tone_in = 1'b0;
    cyc(50);
    enable = 1'b0;
    cyc(1);
    enable = 1'b1;
    outs("en_off", 7'h00, 19'd0);
    chk("en_off.state", 32'(dut.r_state), 32'(IDLE));
    go_low_then_first_rise(P_B);
    edge_chk("en_b2", P_B, 7'h00, 7'h00, 19'd0);
    edge_chk("en_b3", P_B, 7'h00, 7'h00, 19'd0);
    edge_chk("en_b4", P_B, 7'h00, 7'h40, 19'd202478);
    cyc(P_B / 2 - since);
    tone_in = 1'b0;
    cyc(50);
    rst_n = 1'b0;
    #1;
    outs("rst_mid", 7'h00, 19'd0);
    chk("rst_mid.state", 32'(dut.r_state), 32'(IDLE));
    cyc(1);
    rst_n = 1'b1;
    go_low_then_first_rise(P_B);
    edge_chk("rst_b2", P_B, 7'h00, 7'h00, 19'd0);
    edge_chk("rst_b3", P_B, 7'h00, 7'h00, 19'd0);
    edge_chk("rst_b4", P_B, 7'h00, 7'h40, 19'd202478);
    cyc(P_B / 2 - since);
    tone_in = 1'b0;
    cyc(400002 - since);
    chk("tmo_pre.state", 32'(dut.r_state), 32'(LOCKED));
    chk("tmo_pre.note", 32'(note), 32'(7'h40));
    cyc(1);
    chk("tmo.state", 32'(dut.r_state), 32'(IDLE));
    chk("tmo.note", 32'(note), 32'(0));
    chk("tmo.valid", 32'(valid), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tone_detector.md
TONE_DETECTOR -- requirements
Module: tone_detector

Interface
REQ-001 SHALL have parameter TIMEOUT, default 400000, meaning the cycle count without a rising edge that declares no tone.
REQ-002 SHALL have parameter LOCK_CNT, default 3, meaning the number of consecutive same-class periods needed to lock.
REQ-003 SHALL have port clk, input, 1, the 100 MHz system clock; all flops on posedge.
REQ-004 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1; low forces IDLE and zero outputs.
REQ-006 SHALL have port tone_in, input, 1, an asynchronous square wave (C4..B4 band).
REQ-007 SHALL have port note, output, 7, one-hot detected note: bit0 C4, bit1 D4, bit2 E4, bit3 F4, bit4 G4, bit5 A4, bit6 B4.
REQ-008 SHALL have port valid, output, 1, high exactly when note is nonzero.
REQ-009 SHALL have port period, output, 19, the last locked period in clk cycles.

Function
REQ-010 SHALL synchronise tone_in through 2 flops, then register the result once more for rising-edge detection; edge pulse is 1 cycle wide, 3 cycles after the tone_in rise.
REQ-011 SHALL use a 19-bit period counter that is cleared on an edge pulse and increments otherwise, saturating at TIMEOUT; measured period p is the cycle distance between consecutive edge pulses.
REQ-012 SHALL classify p by half-open windows [lo,hi): C 361374..400000, D 321950..361374, E 294857..321950, F 270723..294857, G 241187..270723, A 214875..241187, B 190000..214875; anything else is unmatched.
REQ-013 SHALL implement the FSM states IDLE (no edge yet), MEASURE (first edge seen, not locked) and LOCKED.
REQ-014 IDLE SHALL go to MEASURE on an edge pulse; no class is evaluated on that first edge.
REQ-015 In MEASURE, a classified period SHALL increment the candidate count if its class equals the candidate, else set candidate to the class with count 1; reaching LOCK_CNT SHALL go to LOCKED and load note, valid and period.
REQ-016 In LOCKED, a period of the locked class SHALL update the period output only.
REQ-017 In LOCKED, a different matched class SHALL run the candidate count while the old note is held; reaching LOCK_CNT SHALL switch note and period in one cycle.
REQ-018 An unmatched period in any state SHALL clear the candidate, drop note and valid to 0, and go to MEASURE.
REQ-019 The counter reaching TIMEOUT in MEASURE or LOCKED SHALL clear the outputs and candidate and go to IDLE.
REQ-020 An edge pulse and TIMEOUT in the same cycle SHALL be treated as the edge, with p = TIMEOUT and therefore unmatched.
REQ-021 Outputs SHALL be registered and SHALL change in the cycle after the deciding edge pulse.
REQ-022 enable low SHALL take priority over all events: IDLE, counter and candidate cleared, outputs 0, with the synchronizer still running.

Reset
REQ-023 rst_n low SHALL asynchronously clear the synchronizer flops, counter, candidate, FSM (to IDLE), note=0, valid=0 and period=0.
REQ-024 Reset deassertion mid-tone SHALL require a fresh first edge plus LOCK_CNT periods before valid rises.

Structure
REQ-025 A shared package tone_pkg SHALL hold the note-class enum, the FSM state enum, the window bound constants and the nominal periods (C 382219, D 340530, E 303370, F 286344, G 255102, A 227273, B 202478).
REQ-026 A combinational sub-module period_classifier SHALL map p to a class and a matched flag.

Verification
REQ-027 A 382219-cycle square wave for 5 periods SHALL give note=7'b0000001, valid=1 and period=382219 one cycle after the 4th rising edge pulse.
REQ-028 A locked A4 (227273) changed to B4 (202478) SHALL hold note=7'b0100000 for 2 B periods, then give 7'b1000000 after the 3rd.
REQ-029 A locked tone with tone_in stuck low SHALL give note=0, valid=0 and FSM IDLE exactly 400000 cycles after the last edge pulse.
REQ-030 Period 150000 after lock SHALL give note=0 immediately; the boundaries 214874 (B) and 214875 (A) SHALL each classify as stated.
REQ-031 rst_n pulsed low mid-LOCKED, or enable low for 1 cycle, SHALL give all outputs 0 at once and relock only after 1+3 edges.
